// File: rtl/ctrl_unit_q_if.sv
// Host-command and engine-handshake bundle for ctrl_unit_q.
// The slave modport is the control unit. The master modport is the host/engine side.
interface ctrl_unit_q_if #(
  parameter int unsigned RF_ADDR_W      = 10,
  parameter int unsigned CMD_FIFO_DEPTH = 8,
  parameter int unsigned NUM_EU         = 4
);
  localparam int unsigned LVL_W = $clog2(CMD_FIFO_DEPTH + 1);

  // host side
  logic [31:0]           h2f_io;
  logic                  h2f_write;
  logic                  err_clr;
  logic                  isrunning;
  logic [LVL_W-1:0]      fifo_level;
  logic                  err_overflow;
  logic                  err_badid;
  logic                  err_timeout;
  // load/store engine
  logic                  load_start;
  logic                  store_start;
  logic [31:0]           ldst_sdram_addr;
  logic [RF_ADDR_W-1:0]  ldst_rf_addr;
  logic [7:0]            ldst_line_num;
  logic                  ldst_done;
  // move engine
  logic                  move_start;
  logic [RF_ADDR_W-1:0]  move_src_addr;
  logic [RF_ADDR_W-1:0]  move_dst_addr;
  logic [7:0]            move_line_num;
  logic                  move_done;
  // execution units
  logic [NUM_EU-1:0]     eu_fetch;
  logic [NUM_EU-1:0]     eu_exec;
  logic [23:0]           eu_fetch_addr;
  logic [NUM_EU-1:0]     eu_done;

  modport slave (
    input  h2f_io, h2f_write, err_clr, ldst_done, move_done, eu_done,
    output isrunning, fifo_level, err_overflow, err_badid, err_timeout,
           load_start, store_start, ldst_sdram_addr, ldst_rf_addr, ldst_line_num,
           move_start, move_src_addr, move_dst_addr, move_line_num,
           eu_fetch, eu_exec, eu_fetch_addr
  );

  modport master (
    output h2f_io, h2f_write, err_clr, ldst_done, move_done, eu_done,
    input  isrunning, fifo_level, err_overflow, err_badid, err_timeout,
           load_start, store_start, ldst_sdram_addr, ldst_rf_addr, ldst_line_num,
           move_start, move_src_addr, move_dst_addr, move_line_num,
           eu_fetch, eu_exec, eu_fetch_addr
  );
endinterface

// File: rtl/ctrl_unit_q.sv
// Queued host-command control unit: FIFO-buffered 32b commands dispatched one at a
// time to load/store, move and NUM_EU execution-unit engines.
// Optional macro CU_TIMEOUT_EN enables the WAIT watchdog (err_timeout).
module ctrl_unit_q #(
  parameter int unsigned RF_ADDR_W      = 10,
  parameter int unsigned CMD_FIFO_DEPTH = 8,
  parameter int unsigned NUM_EU         = 4,
  parameter logic [31:0] SDRAM_BASE     = 32'h0,
  parameter int unsigned SDRAM_SHIFT    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic          clk,
  input logic          rst,
  ctrl_unit_q_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(CMD_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_STORE = 2'b01,
                            OP_MOVE = 2'b10, OP_EU    = 2'b11} op_t;

  logic [31:0]          mem_q [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     count_q;
  logic                 full, empty, push, pop;

  state_t               state_q, state_d;
  logic [31:0]          cmd_q;
  op_t                  op, wait_op_q, wait_op_d;
  logic [7:0]           lines;
  logic [4:0]           eu_id;
  logic                 id_ok, done_hit;
  logic [NUM_EU-1:0]    eu_onehot, eu_sel_q, eu_sel_d;

  logic                 load_q, load_d, store_q, store_d, move_q, move_d;
  logic [NUM_EU-1:0]    fetch_q, fetch_d, exec_q, exec_d;
  logic [31:0]          sdram_q, sdram_d;
  logic [RF_ADDR_W-1:0] ldst_rf_q, ldst_rf_d, src_q, src_d, dst_q, dst_d;
  logic [7:0]           ldst_lines_q, ldst_lines_d, move_lines_q, move_lines_d;
  logic [23:0]          faddr_q, faddr_d;
  logic                 ovf_q, badid_q, badid_set;
`ifdef CU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 tmo_q, tmo_set;
`endif

  assign full  = (count_q == LVL_W'(CMD_FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.h2f_write && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  assign op        = op_t'(cmd_q[31:30]);
  assign lines     = cmd_q[7:0];
  assign eu_id     = cmd_q[28:24];
  assign id_ok     = ({27'b0, eu_id} < NUM_EU);
  assign eu_onehot = id_ok ? (NUM_EU'(1) << eu_id) : '0;

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.h2f_io;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Completion only from the engine currently being waited on
  always_comb begin
    done_hit = 1'b0;
    case (wait_op_q)
      OP_LOAD, OP_STORE: done_hit = bus.ldst_done;
      OP_MOVE:           done_hit = bus.move_done;
      default:           done_hit = |(bus.eu_done & eu_sel_q);
    endcase
  end

  // Dispatcher next state; pulses/fields are registered when leaving ISSUE,
  // so the pulse cycle is the first WAIT cycle and done is sampled there too
  always_comb begin
    state_d      = state_q;
    wait_op_d    = wait_op_q;
    eu_sel_d     = eu_sel_q;
    load_d       = 1'b0;
    store_d      = 1'b0;
    move_d       = 1'b0;
    fetch_d      = '0;
    exec_d       = '0;
    sdram_d      = sdram_q;
    ldst_rf_d    = ldst_rf_q;
    ldst_lines_d = ldst_lines_q;
    src_d        = src_q;
    dst_d        = dst_q;
    move_lines_d = move_lines_q;
    faddr_d      = faddr_q;
    badid_set    = 1'b0;
`ifdef CU_TIMEOUT_EN
    wait_cnt_d   = '0;
    tmo_set      = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (!empty) state_d = S_ISSUE;
      S_ISSUE: begin
        state_d   = S_IDLE;
        wait_op_d = op;
        case (op)
          OP_LOAD, OP_STORE: begin
            sdram_d      = SDRAM_BASE + (32'(cmd_q[20:8]) << SDRAM_SHIFT);
            ldst_rf_d    = RF_ADDR_W'(cmd_q[29:21]);
            ldst_lines_d = lines;
            if (lines != '0) begin
              load_d  = (op == OP_LOAD);
              store_d = (op == OP_STORE);
              state_d = S_WAIT;
            end
          end
          OP_MOVE: begin
            src_d        = RF_ADDR_W'(cmd_q[29:20]);
            dst_d        = RF_ADDR_W'(cmd_q[19:10]);
            move_lines_d = lines;
            if (lines != '0) begin
              move_d  = 1'b1;
              state_d = S_WAIT;
            end
          end
          default: begin
            if (!id_ok) begin
              badid_set = 1'b1;
            end else if (cmd_q[29]) begin
              exec_d   = eu_onehot;
              eu_sel_d = eu_onehot;
              state_d  = S_WAIT;
            end else begin
              fetch_d = eu_onehot;
              faddr_d = cmd_q[23:0];
            end
          end
        endcase
      end
      S_WAIT: begin
        if (done_hit) begin
          state_d = S_IDLE;
        end
`ifdef CU_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          tmo_set = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dispatcher registers, output pulses/fields and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      wait_op_q    <= OP_LOAD;
      eu_sel_q     <= '0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      move_q       <= 1'b0;
      fetch_q      <= '0;
      exec_q       <= '0;
      sdram_q      <= '0;
      ldst_rf_q    <= '0;
      ldst_lines_q <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      move_lines_q <= '0;
      faddr_q      <= '0;
      ovf_q        <= 1'b0;
      badid_q      <= 1'b0;
`ifdef CU_TIMEOUT_EN
      wait_cnt_q   <= '0;
      tmo_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      if (pop) cmd_q <= mem_q[rd_ptr_q];
      wait_op_q    <= wait_op_d;
      eu_sel_q     <= eu_sel_d;
      load_q       <= load_d;
      store_q      <= store_d;
      move_q       <= move_d;
      fetch_q      <= fetch_d;
      exec_q       <= exec_d;
      sdram_q      <= sdram_d;
      ldst_rf_q    <= ldst_rf_d;
      ldst_lines_q <= ldst_lines_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      move_lines_q <= move_lines_d;
      faddr_q      <= faddr_d;
      ovf_q        <= (ovf_q & ~bus.err_clr) | (bus.h2f_write & full);
      badid_q      <= (badid_q & ~bus.err_clr) | badid_set;
`ifdef CU_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      tmo_q        <= (tmo_q & ~bus.err_clr) | tmo_set;
`endif
    end
  end

  assign bus.isrunning       = !empty || (state_q != S_IDLE);
  assign bus.fifo_level      = count_q;
  assign bus.err_overflow    = ovf_q;
  assign bus.err_badid       = badid_q;
`ifdef CU_TIMEOUT_EN
  assign bus.err_timeout     = tmo_q;
`else
  assign bus.err_timeout     = 1'b0;
`endif
  assign bus.load_start      = load_q;
  assign bus.store_start     = store_q;
  assign bus.ldst_sdram_addr = sdram_q;
  assign bus.ldst_rf_addr    = ldst_rf_q;
  assign bus.ldst_line_num   = ldst_lines_q;
  assign bus.move_start      = move_q;
  assign bus.move_src_addr   = src_q;
  assign bus.move_dst_addr   = dst_q;
  assign bus.move_line_num   = move_lines_q;
  assign bus.eu_fetch        = fetch_q;
  assign bus.eu_exec         = exec_q;
  assign bus.eu_fetch_addr   = faddr_q;
endmodule

// File: tb/tb_ctrl_unit_q.sv
// Bench for ctrl_unit_q: directed command vectors, a transaction-level model of the
// expected engine pulses in command order, and literal spot checks on timing and fields.
module tb_ctrl_unit_q;
  localparam int unsigned RF_W  = 10;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NEU   = 4;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int unsigned SHIFT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_unit_q_if #(.RF_ADDR_W(RF_W), .CMD_FIFO_DEPTH(DEPTH), .NUM_EU(NEU)) bus ();

  ctrl_unit_q #(
    .RF_ADDR_W(RF_W), .CMD_FIFO_DEPTH(DEPTH), .NUM_EU(NEU),
    .SDRAM_BASE(BASE), .SDRAM_SHIFT(SHIFT), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic       auto_done = 1'b0;
  logic       ldst_man  = 1'b0;
  logic       move_man  = 1'b0;
  logic [3:0] eu_man    = 4'b0;
  assign bus.ldst_done = ldst_man | (auto_done & (bus.load_start | bus.store_start));
  assign bus.move_done = move_man | (auto_done & bus.move_start);
  assign bus.eu_done   = eu_man | (auto_done ? bus.eu_exec : 4'b0);

  // kind: 0 load, 1 store, 2 move, 3 fetch, 4 exec
  typedef struct {
    int          kind;
    logic [31:0] sdram;
    logic [9:0]  a;
    logic [9:0]  b;
    logic [7:0]  lines;
    logic [3:0]  onehot;
    logic [23:0] faddr;
  } txn_t;

  txn_t exp_q[$];
  int   pulse_times[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic any_pulse();
    return bus.load_start | bus.store_start | bus.move_start | (|bus.eu_fetch) | (|bus.eu_exec);
  endfunction

  // Expected engine activity for one accepted command, from the command encoding
  task automatic model_push(input logic [31:0] cmd);
    txn_t t;
    logic [1:0] op;
    op = cmd[31:30];
    t.kind = 0; t.sdram = '0; t.a = '0; t.b = '0; t.lines = '0; t.onehot = '0; t.faddr = '0;
    case (op)
      2'b00, 2'b01: if (cmd[7:0] != 8'd0) begin
        t.kind  = int'(op);
        t.sdram = BASE + cmd[20:8] * (32'd1 << SHIFT);
        t.a     = {1'b0, cmd[29:21]};
        t.lines = cmd[7:0];
        exp_q.push_back(t);
      end
      2'b10: if (cmd[7:0] != 8'd0) begin
        t.kind  = 2;
        t.a     = cmd[29:20];
        t.b     = cmd[19:10];
        t.lines = cmd[7:0];
        exp_q.push_back(t);
      end
      default: if (cmd[28:24] < 5'd4) begin
        t.kind   = cmd[29] ? 4 : 3;
        t.onehot = 4'b0001 << cmd[28:24];
        t.faddr  = cmd[23:0];
        exp_q.push_back(t);
      end
    endcase
  endtask

  // Every pulse cycle must match the oldest outstanding expected transaction
  always @(negedge clk) begin
    int   n, k;
    txn_t t;
    if (!rst && any_pulse()) begin
      n = int'(bus.load_start) + int'(bus.store_start) + int'(bus.move_start)
        + $countones(bus.eu_fetch) + $countones(bus.eu_exec);
      k = bus.load_start ? 0 : bus.store_start ? 1 : bus.move_start ? 2 : (|bus.eu_fetch) ? 3 : 4;
      pulse_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 64'(n), 64'd0);
      end else begin
        t = exp_q.pop_front();
        chk("pulse_count", 64'(n), 64'd1);
        chk("pulse_kind", 64'(k), 64'(t.kind));
        case (t.kind)
          0, 1: begin
            chk("ldst_sdram", bus.ldst_sdram_addr, t.sdram);
            chk("ldst_rf", bus.ldst_rf_addr, t.a);
            chk("ldst_lines", bus.ldst_line_num, t.lines);
          end
          2: begin
            chk("move_src", bus.move_src_addr, t.a);
            chk("move_dst", bus.move_dst_addr, t.b);
            chk("move_lines", bus.move_line_num, t.lines);
          end
          3: begin
            chk("fetch_onehot", bus.eu_fetch, t.onehot);
            chk("fetch_addr", bus.eu_fetch_addr, t.faddr);
          end
          default: chk("exec_onehot", bus.eu_exec, t.onehot);
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [31:0] cmd, input logic dropped);
    bus.h2f_io    = cmd;
    bus.h2f_write = 1'b1;
    if (!dropped) model_push(cmd);
    @(negedge clk);
    bus.h2f_write = 1'b0;
  endtask

  task automatic wait_pulse(input string name, input int max);
    int n = 0;
    while (!any_pulse() && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, any_pulse(), 1'b1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while ((bus.isrunning || bus.fifo_level != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.isrunning, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.h2f_io    = '0;
    bus.h2f_write = 1'b0;
    bus.err_clr   = 1'b0;
    tick(3);
    chk("rst_isrunning", bus.isrunning, 1'b0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_errs", {bus.err_overflow, bus.err_badid, bus.err_timeout}, 3'b000);
    chk("rst_pulses", any_pulse(), 1'b0);
    rst = 1'b0;
    tick(1);

    // LOAD: pulse in the cycle after edge N+2, then hold until ldst_done
    host_write(32'h0012_3466, 1'b0);
    tick(1);
    chk("load_latency_early", bus.load_start, 1'b0);
    chk("load_running", bus.isrunning, 1'b1);
    tick(1);
    chk("load_pulse", bus.load_start, 1'b1);
    chk("load_sdram_lit", bus.ldst_sdram_addr, 32'h0048_D000);
    chk("load_lines_lit", bus.ldst_line_num, 8'h66);
    chk("load_rf_lit", bus.ldst_rf_addr, 10'd0);
    tick(1);
    chk("load_one_cycle", bus.load_start, 1'b0);
    tick(3);
    chk("load_hold", bus.isrunning, 1'b1);
    chk("no_timeout_yet", bus.err_timeout, 1'b0);
    ldst_man = 1'b1;
    tick(1);
    ldst_man = 1'b0;
    chk("load_released", bus.isrunning, 1'b0);

    // Overflow while stalled in WAIT, then in-order drain at full throughput
    host_write(32'h40A0_0304, 1'b0);
    tick(2);
    for (int i = 0; i < 9; i++)
      host_write(32'h8000_0000 | (32'(i) << 20) | (32'(i + 100) << 10) | 32'(i + 1), i == 8);
    chk("ovf_level", bus.fifo_level, 8);
    chk("ovf_flag", bus.err_overflow, 1'b1);
    auto_done = 1'b1;
    pulse_times.delete();
    ldst_man = 1'b1;
    tick(1);
    ldst_man = 1'b0;
    wait_idle("ovf_drain", 100);
    chk("drain_count", pulse_times.size(), 8);
    if (pulse_times.size() == 8)
      chk("drain_spacing", pulse_times[7] - pulse_times[0], 21);
    chk("ovf_sticky", bus.err_overflow, 1'b1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    chk("ovf_cleared", bus.err_overflow, 1'b0);

    // MOVE field decode
    host_write(32'h8A78_00A6, 1'b0);
    wait_pulse("move_seen", 10);
    chk("move_src_lit", bus.move_src_addr, 10'd167);
    chk("move_dst_lit", bus.move_dst_addr, 10'h200);
    chk("move_lines_lit", bus.move_line_num, 8'd166);
    wait_idle("move_idle", 20);

    // Posted fetch, then exec waiting on its own eu_done only
    auto_done = 1'b0;
    host_write(32'hC234_5678, 1'b0);
    host_write(32'hE200_0000, 1'b0);
    wait_pulse("fetch_seen", 10);
    chk("fetch_lit", bus.eu_fetch, 4'b0100);
    chk("fetch_addr_lit", bus.eu_fetch_addr, 24'h345678);
    tick(1);
    wait_pulse("exec_seen", 10);
    chk("exec_lit", bus.eu_exec, 4'b0100);
    ldst_man = 1'b1; move_man = 1'b1; eu_man = 4'b0010;
    tick(1);
    ldst_man = 1'b0; move_man = 1'b0; eu_man = 4'b0000;
    tick(3);
    chk("exec_ignores_stray", bus.isrunning, 1'b1);
    eu_man = 4'b0100;
    tick(1);
    eu_man = 4'b0000;
    chk("exec_done", bus.isrunning, 1'b0);

    // Bad EU id, err_clr, error-wins, zero-length LOAD
    auto_done = 1'b1;
    host_write(32'hF100_0000, 1'b0);
    tick(3);
    chk("badid_set", bus.err_badid, 1'b1);
    chk("badid_idle", bus.isrunning, 1'b0);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    chk("badid_cleared", bus.err_badid, 1'b0);
    host_write(32'hF100_0000, 1'b0);
    tick(1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    chk("error_beats_clr", bus.err_badid, 1'b1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    host_write(32'h0012_3400, 1'b0);
    tick(1);
    chk("zero_len_issue", bus.isrunning, 1'b1);
    tick(1);
    chk("zero_len_nopulse", bus.load_start, 1'b0);
    chk("zero_len_idle", bus.isrunning, 1'b0);

    // Reset mid-WAIT abandons the command and the queue
    auto_done = 1'b0;
    host_write(32'h8010_0401, 1'b0);
    host_write(32'h8020_0802, 1'b0);
    host_write(32'h8030_0C03, 1'b0);
    tick(2);
    chk("pre_rst_level", bus.fifo_level, 2);
    rst = 1'b1;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    chk("post_rst_level", bus.fifo_level, 0);
    chk("post_rst_running", bus.isrunning, 1'b0);
    move_man = 1'b1;
    tick(1);
    move_man = 1'b0;
    tick(4);
    chk("stray_done_idle", bus.isrunning, 1'b0);

`ifdef CU_TIMEOUT_EN
    // Missing done: watchdog fires after 4096 WAIT cycles, next command proceeds
    host_write(32'h0012_3466, 1'b0);
    host_write(32'h8010_0401, 1'b0);
    wait_pulse("tmo_load_seen", 10);
    begin
      int n = 0;
      while (!bus.err_timeout && n < 5000) begin
        tick(1);
        n++;
      end
      chk("tmo_cycles", 64'(n), 64'd4096);
    end
    chk("tmo_flag", bus.err_timeout, 1'b1);
    auto_done = 1'b1;
    wait_idle("tmo_next_cmd", 20);
`endif

    chk("model_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
